// File: rtl/fsm_bit_serializer_pkg.sv
// Shared types and widths for the bit serializer that feeds the 010 sequence detector.
package fsm_bit_serializer_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } ser_state_e;

    localparam int SER_WORDS_W = 10;
    localparam int SER_GAP_W   = 4;

endpackage

// File: rtl/fsm_bit_serializer_shift_reg.sv
// Loadable word shifter with a per-word direction select and a registered serial output
// that falls back to the idle level whenever it is neither loaded nor shifted.
module ser_shift_reg #(
    parameter int   DATA_W   = 8,
    parameter logic IDLE_BIT = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic              lsb_first,
    input  logic [DATA_W-1:0] data,
    output logic              bit_out
);

    logic [DATA_W-1:0] word_q;
    logic              lsb_q;
    logic              head;

    // The register holds the bits still to be sent; bit_out already carries the current one.
    assign head = lsb_q ? word_q[0] : word_q[DATA_W-1];

    // NOTE: the word register is reset too, so no stale data survives a mid-word reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_q  <= '0;
            lsb_q   <= 1'b0;
            bit_out <= IDLE_BIT;
        end else if (load) begin
            lsb_q   <= lsb_first;
            bit_out <= lsb_first ? data[0] : data[DATA_W-1];
            word_q  <= lsb_first ? (data >> 1) : (data << 1);
        end else if (shift) begin
            bit_out <= head;
            word_q  <= lsb_q ? (word_q >> 1) : (word_q << 1);
        end else begin
            bit_out <= IDLE_BIT;
        end
    end

endmodule

// File: rtl/fsm_bit_serializer.sv
// Valid/ready parallel-to-serial feeder: shifts words onto x_out one bit per clock,
// idles at IDLE_BIT between words and counts completed words modulo 1024.
module fsm_bit_serializer
    import fsm_bit_serializer_pkg::*;
#(
    parameter int   DATA_W     = 8,
    parameter logic IDLE_BIT   = 1'b1,
    parameter int   GAP_CYCLES = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   lsb_first,
    output logic                   x_out,
    output logic                   busy,
    output logic [SER_WORDS_W-1:0] words_sent
);

    localparam int                   CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [SER_GAP_W-1:0] LAST_GAP = SER_GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    ser_state_e             state, state_n;
    logic [CNT_W-1:0]       bit_cnt, bit_cnt_n;
    logic [SER_GAP_W-1:0]   gap_cnt, gap_cnt_n;
    logic [SER_WORDS_W-1:0] words_n;
    logic                   accept;
    logic                   load, shift;
    logic                   in_ready_n, busy_n;

    assign accept = in_valid && in_ready;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            words_sent <= '0;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            gap_cnt    <= gap_cnt_n;
            words_sent <= words_n;
            in_ready   <= in_ready_n;
            busy       <= busy_n;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        gap_cnt_n = gap_cnt;
        words_n   = words_sent;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    state_n   = S_SHIFT;
                    bit_cnt_n = '0;
                end
            end
            S_SHIFT: begin
                bit_cnt_n = bit_cnt + 1'b1;
                if (bit_cnt == LAST_BIT) begin
                    words_n = words_sent + 1'b1;
                    if (GAP_CYCLES > 0) begin
                        state_n   = S_GAP;
                        gap_cnt_n = '0;
                    end else if (accept) begin
                        state_n   = S_SHIFT;
                        bit_cnt_n = '0;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                gap_cnt_n = gap_cnt + 1'b1;
                if (gap_cnt == LAST_GAP) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Outputs are computed one cycle ahead from the next state and registered above.
    always_comb begin
        load       = accept;
        shift      = (state == S_SHIFT) && (bit_cnt != LAST_BIT);
        busy_n     = (state_n == S_SHIFT);
        in_ready_n = (state_n == S_IDLE) ||
                     ((GAP_CYCLES == 0) && (state_n == S_SHIFT) && (bit_cnt_n == LAST_BIT));
    end

    ser_shift_reg #(
        .DATA_W   (DATA_W),
        .IDLE_BIT (IDLE_BIT)
    ) u_shift (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .shift     (shift),
        .lsb_first (lsb_first),
        .data      (in_data),
        .bit_out   (x_out)
    );

endmodule

// File: tb/tb_fsm_bit_serializer.sv
// Directed bench for fsm_bit_serializer: gapless instance plus a GAP_CYCLES=3 instance.
module tb_fsm_bit_serializer;

    logic clk_tb = 1'b0;
    always #5 clk_tb = ~clk_tb;

    logic       rst;
    logic [7:0] in_data;
    logic       in_valid, lsb_first, in_ready, x_out, busy;
    logic [9:0] words_sent;

    logic [7:0] g_in_data;
    logic       g_in_valid, g_lsb_first, g_in_ready, g_x_out, g_busy;
    logic [9:0] g_words_sent;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [9:0] exp_words;

    fsm_bit_serializer #(.DATA_W(8), .IDLE_BIT(1'b1), .GAP_CYCLES(0)) dut (
        .clk(clk_tb), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .lsb_first(lsb_first), .x_out(x_out), .busy(busy), .words_sent(words_sent)
    );

    fsm_bit_serializer #(.DATA_W(8), .IDLE_BIT(1'b1), .GAP_CYCLES(3)) dut_gap (
        .clk(clk_tb), .rst(rst), .in_data(g_in_data), .in_valid(g_in_valid), .in_ready(g_in_ready),
        .lsb_first(g_lsb_first), .x_out(g_x_out), .busy(g_busy), .words_sent(g_words_sent)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk_tb);
            guard++;
        end
        if (!in_ready) check({tag, "_ready_timeout"}, in_ready, 1);
    endtask

    // Sends one word; exp_seq holds the expected bits, first-sent bit in position 7.
    task automatic send_word(input string tag, input logic [7:0] data, input logic lsb,
                             input logic [7:0] exp_seq, output logic [7:0] obs);
        @(negedge clk_tb);
        in_data = data; lsb_first = lsb; in_valid = 1'b1;
        wait_ready(tag);
        @(negedge clk_tb);
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            obs[7-k] = x_out;
            check($sformatf("%s_bit%0d", tag, k), x_out, exp_seq[7-k]);
            if (k == 0) check({tag, "_busy"}, busy, 1);
            @(negedge clk_tb);
        end
        check({tag, "_idle_after"}, {x_out, busy}, 2'b10);
        exp_words++;
        check({tag, "_words"}, words_sent, exp_words);
    endtask

    task automatic send_words(input int n);
        int acc = 0;
        int guard = 0;
        @(negedge clk_tb);
        in_data = 8'hA5; lsb_first = 1'b0; in_valid = 1'b1;
        while (acc < n && guard < n * 8 + 100) begin
            if (in_ready) acc++;
            @(negedge clk_tb);
            guard++;
        end
        in_valid = 1'b0;
        guard = 0;
        while (busy && guard < 20) begin
            @(negedge clk_tb);
            guard++;
        end
        check("stream_drain", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  obs;
        logic [15:0] stream16;
        logic        busy_all;
        logic [9:0]  bits;
        logic [2:0]  hist;
        int          det_count, gap, guard;

        rst = 1'b0;
        in_data = '0; in_valid = 1'b0; lsb_first = 1'b0;
        g_in_data = '0; g_in_valid = 1'b0; g_lsb_first = 1'b0;
        exp_words = '0;
        repeat (3) @(negedge clk_tb);
        check("in_reset", {x_out, busy, words_sent}, {1'b1, 1'b0, 10'd0});
        rst = 1'b1;

        // 1: idle line after reset
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_tb);
            check($sformatf("idle_c%0d", c), {x_out, in_ready, busy, words_sent}, {3'b110, 10'd0});
        end

        // 2, 3: single words, both bit orders
        send_word("w4a_msb", 8'h4A, 1'b0, 8'h4A, obs);
        send_word("w01_lsb", 8'h01, 1'b1, 8'h80, obs);

        // 4: gapless back-to-back FF then 00
        @(negedge clk_tb);
        in_data = 8'hFF; lsb_first = 1'b0; in_valid = 1'b1;
        wait_ready("b2b");
        @(negedge clk_tb);
        in_data = 8'h00;
        busy_all = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            stream16[16-c] = x_out;
            busy_all &= busy;
            if (c == 1) check("b2b_ready_first", in_ready, 0);
            if (c == 8) check("b2b_ready_last", in_ready, 1);
            if (c == 9) in_valid = 1'b0;
            @(negedge clk_tb);
        end
        check("b2b_stream", stream16, 16'hFF00);
        check("b2b_busy_all", busy_all, 1);
        check("b2b_idle_after", {x_out, busy}, 2'b10);
        exp_words += 10'd2;
        check("b2b_words", words_sent, exp_words);

        // 5: GAP_CYCLES=3 between two words
        @(negedge clk_tb);
        g_in_data = 8'h3C; g_lsb_first = 1'b0; g_in_valid = 1'b1;
        @(negedge clk_tb);
        g_in_data = 8'h00;
        repeat (7) @(negedge clk_tb);
        check("gap_last_bit", g_x_out, 0);
        check("gap_ready_last", g_in_ready, 0);
        @(negedge clk_tb);
        gap = 0; guard = 0;
        while (!g_in_ready && guard < 20) begin
            if (g_x_out && !g_busy) gap++;
            @(negedge clk_tb);
            guard++;
        end
        check("gap_len", gap, 3);
        check("gap_idle_ready", g_x_out, 1);
        @(negedge clk_tb);
        g_in_valid = 1'b0;
        check("gap_next_first", {g_x_out, g_busy}, 2'b01);
        check("gap_words", g_words_sent, 1);

        // 7: 8'h52 MSB-first into a 010 overlapping-detector model
        send_word("w52", 8'h52, 1'b0, 8'h52, obs);
        bits = {1'b1, obs, 1'b1};
        hist = 3'b111;
        det_count = 0;
        for (int i = 9; i >= 0; i--) begin
            hist = {hist[1:0], bits[i]};
            if (hist == 3'b010) det_count++;
        end
        check("det_010_count", det_count, 3);

        // 6: asynchronous reset in the middle of 8'h55
        @(negedge clk_tb);
        in_data = 8'h55; lsb_first = 1'b0; in_valid = 1'b1;
        wait_ready("rst_mid");
        @(negedge clk_tb);
        in_valid = 1'b0;
        check("rst_mid_b0", x_out, 0);
        @(negedge clk_tb);
        check("rst_mid_b1", x_out, 1);
        @(negedge clk_tb);
        check("rst_mid_b2", x_out, 0);
        #1 rst = 1'b0;
        #1 check("rst_async", {x_out, busy, in_ready, words_sent}, {3'b101, 10'd0});
        @(negedge clk_tb);
        rst = 1'b1;
        exp_words = '0;
        @(negedge clk_tb);
        check("rst_after", {x_out, busy, words_sent}, {2'b10, 10'd0});

        send_words(1023);
        check("wrap_1023", words_sent, 1023);
        send_words(1);
        check("wrap_0", words_sent, 0);
        check("wrap_idle", {x_out, in_ready}, 2'b11);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
